// File: rtl/barrel_pkg.sv
// barrel_pkg -- shared definitions for the pipelined barrel rotator.
//   WIDTH_DEF : default data width
//   MAX_W     : widest supported word (64); stage records are sized for it
//   MAX_SHW   : widest shift field (log2 of MAX_W)
//   shw_of()  : shift-amount width for a given data width
//   stage_t   : one pipeline stage record (valid, data, shift, dir)
// Optional feature macro: BARREL_ROT_DIR_EN (direction bit, see top).
package barrel_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int MAX_W     = 64;
  localparam int MAX_SHW   = 6;

  function automatic int shw_of(input int w);
    return $clog2(w);
  endfunction

  // Records are sized for the widest word so one typedef serves every
  // WIDTH; a narrower instance only ever touches data[WIDTH-1:0] and
  // shift[SHW-1:0], the rest stays zero.
  typedef struct packed {
    logic               valid;
    logic [MAX_W-1:0]   data;
    logic [MAX_SHW-1:0] shift;
    logic               dir;
  } stage_t;

endpackage

// File: rtl/barrel_rotl_pipe_if.sv
// barrel_rotl_pipe_if -- valid/ready bus of the barrel rotator.
//   in_valid/in_ready/in_data/in_sh : input handshake, word and rotate amount
//   in_dir                          : 0 = left, 1 = right (BARREL_ROT_DIR_EN only)
//   out_valid/out_ready/out_data    : result handshake and rotated word
// Modports: master = producer/consumer side, slave = rotator.
interface barrel_rotl_pipe_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int SHW = shw_of(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_sh;
`ifdef BARREL_ROT_DIR_EN
  logic             in_dir;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

`ifdef BARREL_ROT_DIR_EN
  modport master (
    output in_valid, in_data, in_sh, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_sh, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_data, in_sh, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_sh, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/barrel_rot_stage.sv
// barrel_rot_stage -- one registered rotate stage.
//   clk, rst : clock, async active-high reset
//   d        : record from the previous stage (or the input port)
//   rdy_nxt  : ready of the following stage (out_ready for the last one)
//   rdy      : this stage can take a record this cycle
//   q        : registered record handed to the next stage
// Rotates by STEP when the shift bit of weight STEP is set; rotates right
// instead of left when the record's dir bit is 1.
module barrel_rot_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t d,
  input  logic   rdy_nxt,
  output logic   rdy,
  output stage_t q
);
  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] rot;
  stage_t           nxt;

  always_comb begin
    w   = d.data[WIDTH-1:0];
    rot = d.dir ? ((w >> STEP) | (w << (WIDTH - STEP)))
                : ((w << STEP) | (w >> (WIDTH - STEP)));
    nxt = d;
    if (d.shift[BIT]) nxt.data[WIDTH-1:0] = rot;
    // Consumed bit is cleared so only the pending amount travels on.
    nxt.shift[BIT] = 1'b0;
  end

  // Empty, or the occupant leaves this same cycle.
  assign rdy = !q.valid || rdy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (rdy) begin
      if (d.valid) q <= nxt;
      else         q.valid <= 1'b0;  // payload of an empty slot is don't-care
    end
  end

endmodule

// File: rtl/barrel_rotl_pipe.sv
// barrel_rotl_pipe -- pipelined barrel rotator, one word per cycle.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset, flushes every stage
//   bus : barrel_rotl_pipe_if.slave
//         in_valid/in_ready/in_data/in_sh[/in_dir] -> out_valid/out_ready/out_data
// out_data = in_data rotated left by in_sh, SHW cycles after acceptance.
// Stage k handles the shift bit of weight 2^(SHW-1-k) (MSB first).
// Define BARREL_ROT_DIR_EN to add in_dir (1 = rotate right).
module barrel_rotl_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  barrel_rotl_pipe_if.slave bus
);
  localparam int SHW = shw_of(WIDTH);

  stage_t         stg [SHW+1];  // stg[0] = input record, stg[k+1] = stage k
  logic [SHW:0]   rdy;          // rdy[k] = ready of stage k, rdy[SHW] = out_ready
  stage_t         head;

  always_comb begin
    head            = '0;
    head.valid      = bus.in_valid;
    head.data[WIDTH-1:0] = bus.in_data;
    head.shift[SHW-1:0]  = bus.in_sh;
`ifdef BARREL_ROT_DIR_EN
    head.dir        = bus.in_dir;
`endif
  end

  assign stg[0]   = head;
  assign rdy[SHW] = bus.out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_rot_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << (SHW - 1 - k))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .d       (stg[k]),
      .rdy_nxt (rdy[k+1]),
      .rdy     (rdy[k]),
      .q       (stg[k+1])
    );
  end

  // Ready chain is combinational end to end, so a full pipe still accepts
  // a word in the cycle the consumer drains the last stage.
  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = stg[SHW].valid;
  assign bus.out_data  = stg[SHW].data[WIDTH-1:0];

  // Consumed shift bits, dir and zero padding of the last record have no
  // consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{stg[SHW].shift, stg[SHW].dir, stg[SHW].data};

endmodule
